// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and FSM state type for the instruction fetch stage
package fetch_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with clear/hold/load controls
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hold,
    input  logic              load,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [ADDR_W-1:0] pc4_d,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);

    // clear beats hold beats load; with none of them asserted a bubble is inserted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            pc4   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                valid <= 1'b1;
                instr <= instr_d;
                pc    <= pc_d;
                pc4   <= pc4_d;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with skid buffer and redirect handling
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_plus4;

    logic              skid_valid, skid_valid_nxt;
    logic [DATA_W-1:0] skid_instr, skid_instr_nxt;
    logic [ADDR_W-1:0] skid_pc, skid_pc_nxt;

    logic              ld;
    logic [DATA_W-1:0] ld_instr;
    logic [ADDR_W-1:0] ld_pc;
    logic [ADDR_W-1:0] ld_pc4;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign ld_pc4    = ld_pc + ADDR_W'(4);
    assign imem_req  = (state == FETCH) && reset;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_valid_nxt = skid_valid;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        ld             = 1'b0;
        ld_instr       = imem_rdata;
        ld_pc          = pc;

        if (redirect) begin
            pc_nxt         = redirect_pc & ~ADDR_W'(3);
            skid_valid_nxt = 1'b0;
            // A granted or still-pending request belongs to the old path; DROP swallows its response
            case (state)
                FETCH:   state_nxt = imem_gnt ? DROP : FETCH;
                WAIT:    state_nxt = imem_rvalid ? FETCH : DROP;
                DROP:    state_nxt = imem_rvalid ? FETCH : DROP;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_gnt) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_nxt = pc_plus4;
                        if (!id_stall) begin
                            ld        = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            skid_valid_nxt = 1'b1;
                            skid_instr_nxt = imem_rdata;
                            skid_pc_nxt    = pc;
                            state_nxt      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        ld             = skid_valid;
                        ld_instr       = skid_instr;
                        ld_pc          = skid_pc;
                        skid_valid_nxt = 1'b0;
                        state_nxt      = FETCH;
                    end
                end
                default: begin
                    if (imem_rvalid) begin
                        state_nxt = FETCH;
                    end
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .clear   (redirect),
        .hold    (id_stall),
        .load    (ld),
        .instr_d (ld_instr),
        .pc_d    (ld_pc),
        .pc4_d   (ld_pc4),
        .valid   (if_id_valid),
        .instr   (if_id_instr),
        .pc      (if_id_pc),
        .pc4     (if_id_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_stall, redirect, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc4;

    logic        w_stall, w_redirect, w_gnt, w_rvalid;
    logic [31:0] w_redirect_pc, w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    fetch_stage u_dut (
        .clk         (clk),
        .reset       (reset),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .id_stall    (w_stall),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_gnt    (w_gnt),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .if_id_valid (w_valid),
        .if_id_instr (w_instr),
        .if_id_pc    (w_pc),
        .if_id_pc4   (w_pc4)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] rpc,
                                input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        vec_t r;
        r.stall = stall; r.redir = redir; r.rpc = rpc; r.gnt = gnt; r.rvalid = rvalid; r.rdata = rdata;
        r.req = req; r.addr = addr; r.v = v; r.instr = instr; r.pc = pc; r.pc4 = pc4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // stall redir rpc         gnt rv rdata          | req addr          v instr          pc             pc4
        vecs[0]  = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,        32'h0,         32'h0);
        vecs[1]  = mk(0, 0, 32'h0,   1, 1, 32'hA000_0000, 0, 32'h0000_0000, 1, 32'hA000_0000, 32'h0000_0000, 32'h0000_0004);
        vecs[2]  = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0,        32'h0,         32'h0);
        vecs[3]  = mk(0, 0, 32'h0,   1, 1, 32'hA000_0004, 0, 32'h0000_0004, 1, 32'hA000_0004, 32'h0000_0004, 32'h0000_0008);
        vecs[4]  = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0008, 0, 32'h0,        32'h0,         32'h0);
        vecs[5]  = mk(0, 0, 32'h0,   1, 1, 32'hA000_0008, 0, 32'h0000_0008, 1, 32'hA000_0008, 32'h0000_0008, 32'h0000_000C);
        vecs[6]  = mk(1, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'hA000_0008, 32'h0000_0008, 32'h0000_000C);
        vecs[7]  = mk(1, 0, 32'h0,   1, 1, 32'hA000_000C, 0, 32'h0000_000C, 1, 32'hA000_0008, 32'h0000_0008, 32'h0000_000C);
        vecs[8]  = mk(1, 0, 32'h0,   1, 0, 32'h0,         0, 32'h0000_0010, 1, 32'hA000_0008, 32'h0000_0008, 32'h0000_000C);
        vecs[9]  = mk(0, 0, 32'h0,   1, 0, 32'h0,         0, 32'h0000_0010, 1, 32'hA000_000C, 32'h0000_000C, 32'h0000_0010);
        vecs[10] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,        32'h0,         32'h0);
        vecs[11] = mk(0, 0, 32'h0,   1, 1, 32'hA000_0010, 0, 32'h0000_0010, 1, 32'hA000_0010, 32'h0000_0010, 32'h0000_0014);
        vecs[12] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0014, 0, 32'h0,        32'h0,         32'h0);
        vecs[13] = mk(0, 1, 32'h103, 0, 0, 32'h0,         0, 32'h0000_0014, 0, 32'h0,        32'h0,         32'h0);
        vecs[14] = mk(0, 0, 32'h0,   0, 1, 32'hDEAD_BEEF, 0, 32'h0000_0100, 0, 32'h0,        32'h0,         32'h0);
        vecs[15] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,        32'h0,         32'h0);
        vecs[16] = mk(0, 0, 32'h0,   0, 1, 32'hA000_0100, 0, 32'h0000_0100, 1, 32'hA000_0100, 32'h0000_0100, 32'h0000_0104);
        vecs[17] = mk(0, 1, 32'h200, 1, 0, 32'h0,         1, 32'h0000_0104, 0, 32'h0,        32'h0,         32'h0);
        vecs[18] = mk(0, 0, 32'h0,   0, 1, 32'hBAD0_0104, 0, 32'h0000_0200, 0, 32'h0,        32'h0,         32'h0);
        vecs[19] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0200, 0, 32'h0,        32'h0,         32'h0);
        vecs[20] = mk(0, 0, 32'h0,   0, 1, 32'hA000_0200, 0, 32'h0000_0200, 1, 32'hA000_0200, 32'h0000_0200, 32'h0000_0204);
        vecs[21] = mk(1, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0204, 1, 32'hA000_0200, 32'h0000_0200, 32'h0000_0204);
        vecs[22] = mk(1, 1, 32'h300, 0, 0, 32'h0,         0, 32'h0000_0204, 0, 32'h0,        32'h0,         32'h0);
        vecs[23] = mk(0, 0, 32'h0,   0, 1, 32'hCAFE_F00D, 0, 32'h0000_0300, 0, 32'h0,        32'h0,         32'h0);
        vecs[24] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0300, 0, 32'h0,        32'h0,         32'h0);
        vecs[25] = mk(0, 0, 32'h0,   0, 1, 32'hA000_0300, 0, 32'h0000_0300, 1, 32'hA000_0300, 32'h0000_0300, 32'h0000_0304);
        vecs[26] = mk(0, 0, 32'h0,   0, 1, 32'h1111_1111, 1, 32'h0000_0304, 0, 32'h0,        32'h0,         32'h0);
        vecs[27] = mk(0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h0000_0304, 0, 32'h0,        32'h0,         32'h0);
        vecs[28] = mk(0, 0, 32'h0,   0, 1, 32'hA000_0304, 0, 32'h0000_0304, 1, 32'hA000_0304, 32'h0000_0304, 32'h0000_0308);

        reset = 1'b0;
        id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst req",   32'(imem_req),    32'h0);
        chk("rst addr",  imem_addr,        32'h0);
        chk("rst valid", 32'(if_id_valid), 32'h0);
        chk("rst instr", if_id_instr,      32'h0);
        chk("rst pc",    if_id_pc,         32'h0);
        chk("rst pc4",   if_id_pc4,        32'h0);
        chk("wrap rst req",  32'(w_req), 32'h0);
        chk("wrap rst addr", w_addr,     32'hFFFF_FFFC);

        reset = 1'b1;
        #1;
        chk("first req",  32'(imem_req), 32'h1);
        chk("first addr", imem_addr,     32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            id_stall    = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d req", i),  32'(imem_req), 32'(vecs[i].req));
            chk($sformatf("v%0d addr", i), imem_addr,     vecs[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 32'(if_id_valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                chk($sformatf("v%0d instr", i), if_id_instr, vecs[i].instr);
                chk($sformatf("v%0d pc", i),    if_id_pc,    vecs[i].pc);
                chk($sformatf("v%0d pc4", i),   if_id_pc4,   vecs[i].pc4);
            end
        end

        // reset while a request is outstanding; the late response must be ignored
        @(negedge clk);
        id_stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("midwait req",  32'(imem_req), 32'h1);
        chk("midwait addr", imem_addr,     32'h0000_0308);
        @(negedge clk);
        imem_gnt = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst req",   32'(imem_req),    32'h0);
        chk("midrst valid", 32'(if_id_valid), 32'h0);
        chk("midrst instr", if_id_instr,      32'h0);
        chk("midrst pc4",   if_id_pc4,        32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("relrst req",  32'(imem_req), 32'h1);
        chk("relrst addr", imem_addr,     32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_7777;
        @(posedge clk);
        #1;
        chk("late rsp valid", 32'(if_id_valid), 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        chk("late rsp req",  32'(imem_req), 32'h1);
        chk("late rsp addr", imem_addr,     32'h0);

        // wrap-around of pc+4 from the top of the address space
        w_gnt = 1'b1;
        #1;
        chk("wrap req0",  32'(w_req), 32'h1);
        chk("wrap addr0", w_addr,     32'hFFFF_FFFC);
        @(negedge clk);
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
        #1;
        chk("wrap wait req", 32'(w_req), 32'h0);
        @(posedge clk);
        #1;
        chk("wrap valid", 32'(w_valid), 32'h1);
        chk("wrap instr", w_instr,      32'h1234_5678);
        chk("wrap pc",    w_pc,         32'hFFFF_FFFC);
        chk("wrap pc4",   w_pc4,        32'h0);
        @(negedge clk);
        w_rvalid = 1'b0;
        #1;
        chk("wrap req1",  32'(w_req), 32'h1);
        chk("wrap addr1", w_addr,     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, instruction width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1: single clock, rising edge.
- reset input 1: asynchronous, active-low reset.
- id_stall input 1: decode cannot accept; hold IF/ID.
- redirect input 1: branch/jump taken; refetch from redirect_pc.
- redirect_pc input ADDR_W: redirect target.
- imem_req output 1: fetch request valid.
- imem_addr output ADDR_W: fetch address.
- imem_gnt input 1: request accepted this cycle.
- imem_rvalid input 1: response valid.
- imem_rdata input DATA_W: response instruction.
- if_id_valid output 1: IF/ID holds a live instruction.
- if_id_instr output DATA_W: instruction to decode.
- if_id_pc output ADDR_W: its address.
- if_id_pc4 output ADDR_W: its address + 4.
REQ-003 The design SHALL use one clock domain (clk) with reset asynchronous and active-low.

Function
REQ-004 The design SHALL hold one PC register and allow at most one outstanding imem request.
REQ-005 The FSM SHALL have states FETCH, WAIT, HOLD, and DROP.
REQ-006 In FETCH: imem_req=1, imem_addr=pc; on imem_gnt the FSM SHALL go to WAIT.
REQ-007 In WAIT, on imem_rvalid with id_stall=0: IF/ID <= {1, rdata, pc, pc+4}, pc <= pc+4, next state FETCH.
REQ-008 In WAIT, on imem_rvalid with id_stall=1: rdata/pc SHALL be captured into a 1-entry skid buffer, pc <= pc+4, next state HOLD; no request SHALL be issued.
REQ-009 In HOLD, when id_stall=0: skid contents SHALL load into IF/ID and the FSM SHALL go to FETCH.
REQ-010 When id_stall=1, all IF/ID outputs SHALL hold their values.
REQ-011 When id_stall=0 and no instruction is delivered this cycle, IF/ID SHALL load if_id_valid=0 (bubble).
REQ-012 Redirect SHALL take priority over id_stall and all other events: if_id_valid <= 0, skid cleared, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
REQ-013 Redirect next state:
- From WAIT without rvalid: DROP.
- From FETCH with imem_gnt the same cycle: DROP, since the granted request is stale.
- Otherwise: FETCH.
REQ-014 In DROP, the next imem_rvalid SHALL be discarded and the FSM SHALL go to FETCH; a further redirect in DROP SHALL update pc only.
REQ-015 pc+4 SHALL wrap modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
REQ-016 The stage latency SHALL be: instruction visible on IF/ID on the clock edge following the imem_rvalid cycle.
REQ-017 imem_rvalid arriving in FETCH or HOLD (protocol error) SHALL be ignored.

Reset
REQ-018 While reset=0, the design SHALL force: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0, skid empty, imem_req=0.
REQ-019 After reset deasserts, imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle.
REQ-020 Reset asserted mid-WAIT SHALL abandon the outstanding request; a late response after reset release SHALL be treated as a REQ-017 error.

Structure
REQ-021 Package fetch_pkg SHALL hold the FSM state enum, the RESET_PC default, and the ADDR_W/DATA_W defaults.
REQ-022 Sub-module if_id_reg SHALL implement the IF/ID register with load/hold/clear controls; the FSM, PC, and skid SHALL reside in fetch_stage.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset release, memory always grants and responds next cycle -> addresses 0x0, 0x4, 0x8 issued; IF/ID shows instr@0x0 with pc4=0x4, then the next instructions in order, no gaps beyond one bubble per fetch.
- id_stall=1 for 3 cycles while a response arrives -> IF/ID frozen, no imem_req during HOLD; on release the skid instruction appears once and is never duplicated.
- Redirect to 0x0000_0103 while in WAIT -> next rvalid dropped, next request addr=0x0000_0100, if_id_valid=0 that cycle.
- Redirect coincident with imem_gnt in FETCH -> the stale response is dropped; the fetch targets the redirect address.
- Redirect and id_stall both high -> IF/ID cleared (if_id_valid=0) despite the stall.
- RESET_PC=32'hFFFF_FFFC -> the second fetch addresses 0x0000_0000, with if_id_pc4=0x0 on the first instruction.
